accum_seq_ctrl: RTL

- Sequencer in front of the 3-slot operand Accumulator. Gathers 1-3 operand bytes from two requesters under round-robin arbitration into a staging buffer.
- Replays the staged bytes to the Accumulator as an unbroken putFlag burst, since the Accumulator requires consecutive put cycles per group.
- Then forces a put-low gap cycle so the Accumulator closes the group, and pulses done.

---
 rtl/accum_seq_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl
// ---------------------------------------------------------------------------
// Sequencer in front of the 3-slot operand Accumulator.
// - Gathers 1..3 operand bytes from two requesters into a staging buffer.
//   The requesters are served round-robin.
// - Replays the staged bytes as one unbroken acc_put burst.
// - Forces a single put-low gap cycle so the Accumulator closes the group.
// - Pulses done during that gap cycle.
//
// Optional feature, selected by macro ACCUM_SEQ_TIMEOUT_EN:
// - Adds a GATHER idle timeout.
// - A partially gathered group is delivered short when the timeout expires.
// - An empty group is abandoned with err.
// - Without the macro, GATHER waits indefinitely and timeout stays 0.
//
// Parameters:
//   DW          operand/data width
//   TIMEOUT_CYC GATHER idle limit in cycles (only with ACCUM_SEQ_TIMEOUT_EN)
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      begin a group (sampled only in IDLE)
//   op_count   operands in group, 1..3 (sampled with start)
//   req_valid  requester i has an operand
//   req_data   requester i data in [i*DW +: DW]
//   req_ready  one-hot grant (combinational)
//   acc_put    Accumulator putFlag
//   acc_value  Accumulator value
//   busy       state != IDLE
//   done       one-cycle pulse, group delivered
//   err        one-cycle pulse, bad start or empty timeout
//   timeout    one-cycle pulse, gather timed out
//   gathered   operands staged so far / burst length
module accum_seq_ctrl #(
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op_count,
  input  logic [1:0]      req_valid,
  input  logic [2*DW-1:0] req_data,
  output logic [1:0]      req_ready,
  output logic            acc_put,
  output logic [DW-1:0]   acc_value,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            timeout,
  output logic [1:0]      gathered
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATHER,
    S_BURST,
    S_GAP
  } state_t;

  state_t          r_state;
  logic            r_rr;
  logic [1:0]      r_count;
  logic [1:0]      r_gathered;
  logic [1:0]      r_beat;
  logic [DW-1:0]   r_stage0;
  logic [DW-1:0]   r_stage1;
  logic [DW-1:0]   r_stage2;
  logic            r_acc_put;
  logic [DW-1:0]   r_acc_value;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_timeout;

  logic [1:0]      w_grant;
  logic            w_xfer;
  logic            w_sel;
  logic [DW-1:0]   w_data;
  logic [1:0]      w_gathered_nx;
  logic [DW-1:0]   w_beat_value;

`ifdef ACCUM_SEQ_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0]   r_idle;
`else
  logic            w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // One grant per cycle.
  // When both requesters are valid, r_rr picks the winner.
  always_comb begin
    w_grant = '0;
    if (r_state == S_GATHER) begin
      case (req_valid)
        2'b11:   w_grant = r_rr ? 2'b10 : 2'b01;
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        default: w_grant = '0;
      endcase
    end
  end

  assign w_xfer        = |w_grant;
  assign w_sel         = w_grant[1];
  assign w_data        = w_sel ? req_data[2*DW-1:DW] : req_data[DW-1:0];
  assign w_gathered_nx = r_gathered + 2'd1;

  always_comb begin
    case (r_beat)
      2'd1:    w_beat_value = r_stage1;
      2'd2:    w_beat_value = r_stage2;
      default: w_beat_value = r_stage0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr        <= 1'b0;
      r_count     <= '0;
      r_gathered  <= '0;
      r_beat      <= '0;
      r_stage0    <= '0;
      r_stage1    <= '0;
      r_stage2    <= '0;
      r_acc_put   <= 1'b0;
      r_acc_value <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef ACCUM_SEQ_TIMEOUT_EN
      r_idle      <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (op_count == 2'd0) begin
              r_err <= 1'b1;
            end else begin
              r_count    <= op_count;
              r_gathered <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_GATHER;
`ifdef ACCUM_SEQ_TIMEOUT_EN
              r_idle     <= '0;
`endif
            end
          end
        end

        S_GATHER: begin
          if (w_xfer) begin
            case (r_gathered)
              2'd0:    r_stage0 <= w_data;
              2'd1:    r_stage1 <= w_data;
              default: r_stage2 <= w_data;
            endcase
            r_gathered <= w_gathered_nx;
            r_rr       <= ~w_sel;
`ifdef ACCUM_SEQ_TIMEOUT_EN
            r_idle     <= '0;
`endif
            if (w_gathered_nx == r_count) begin
              // The first beat leaves on this same edge.
              // In a 1-operand group, slot 0 is still being written here,
              // so the beat is taken straight from the granted data.
              r_state     <= S_BURST;
              r_acc_put   <= 1'b1;
              r_acc_value <= (r_gathered == 2'd0) ? w_data : r_stage0;
              r_beat      <= 2'd1;
            end
          end
`ifdef ACCUM_SEQ_TIMEOUT_EN
          else if (r_idle == IW'(TIMEOUT_CYC - 1)) begin
            r_timeout <= 1'b1;
            if (r_gathered != 2'd0) begin
              r_count     <= r_gathered;
              r_state     <= S_BURST;
              r_acc_put   <= 1'b1;
              r_acc_value <= r_stage0;
              r_beat      <= 2'd1;
            end else begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_idle <= r_idle + 1'b1;
          end
`endif
        end

        S_BURST: begin
          if (r_beat == r_gathered) begin
            r_acc_put <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_GAP;
          end else begin
            r_acc_value <= w_beat_value;
            r_beat      <= r_beat + 2'd1;
          end
        end

        S_GAP: begin
          r_gathered <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign acc_put   = r_acc_put;
  assign acc_value = r_acc_value;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign timeout   = r_timeout;
  assign gathered  = r_gathered;

endmodule
